hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_EXTRA, default 1, range 0..3: the number of extra IF/ID flush cycles after the mispredict-detect cycle.
REQ-002 The block SHALL have parameter CNT_W, default 32: the width of the stall counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-007 id_rs1_en, id_rs2_en  in  1 each  ID source reads are real.
REQ-008 ex_rd  in  5  destination of the instruction in EX.
REQ-009 ex_rd_en  in  1  EX instruction writes rd.
REQ-010 ex_is_load  in  1  EX instruction is a load.
REQ-011 ex_mispredict  in  1  branch/jump resolved wrong in EX this cycle.
REQ-012 md_start  in  1  EX issues a multi-cycle mul/div this cycle.
REQ-013 md_done  in  1  mul/div result valid this cycle.
REQ-014 pc_stall, ifid_stall  out  1 each  hold PC and the IF/ID register.
REQ-015 ifid_flush  out  1  bubble the IF/ID register.
REQ-016 idex_stall  out  1  drives the ID/EX register feedforward_stall input.
REQ-017 idex_flush  out  1  drives the ID/EX register checkpre_flush input.
REQ-018 stall_cnt  out  CNT_W  count of cycles with pc_stall=1.

Function
REQ-019 The FSM SHALL have the states RUN, MD_WAIT and REDIRECT; the outputs SHALL be combinational (Mealy) from state, the flush counter and the inputs.
REQ-020 Load-use SHALL be defined as: ex_is_load & ex_rd_en & ex_rd!=0 & ((id_rs1_en & id_rs1==ex_rd) | (id_rs2_en & id_rs2==ex_rd)).
REQ-021 RUN with ex_mispredict=1: ifid_flush=1 and idex_flush=1 in the same cycle, with no stalls. If FLUSH_EXTRA>0, the next state SHALL be REDIRECT with the counter loaded to FLUSH_EXTRA; otherwise the state SHALL stay RUN.
REQ-022 REDIRECT: ifid_flush=1 and idex_flush=1 each cycle; the counter SHALL decrement, and the state SHALL return to RUN after the cycle in which the counter equals 1; the load-use and md_start inputs SHALL be ignored.
REQ-023 RUN with md_start=1 and no mispredict: no stall in the issue cycle, and the next state SHALL be MD_WAIT.
REQ-024 MD_WAIT with md_done=0: pc_stall=ifid_stall=idex_stall=1. With md_done=1: no stall outputs, and the next state SHALL be RUN.
REQ-025 The block SHALL ignore ex_mispredict in MD_WAIT.
REQ-026 RUN with load-use and no mispredict: pc_stall=ifid_stall=1 and idex_flush=1 (one bubble) for exactly that cycle; the state SHALL remain RUN.
REQ-027 Priority in RUN SHALL be: mispredict > md_start > load-use.
REQ-028 If md_start and load-use are both set, md_start SHALL win, and load-use SHALL be re-evaluated after MD_WAIT exits.
REQ-029 stall_cnt SHALL increment by 1 on each clock edge where pc_stall=1, and SHALL saturate at all-ones with no wrap.
REQ-030 idex_stall and idex_flush SHALL never both be 1 in the same cycle.
REQ-031 All other outputs SHALL be 0 in any case not listed above.

Reset
REQ-032 While rst=1, all outputs except stall_cnt SHALL be forced to 0.
REQ-033 At a clock edge with rst=1: state SHALL become RUN, the flush counter 0 and stall_cnt 0.
REQ-034 Reset asserted in MD_WAIT or REDIRECT SHALL abandon the operation; the first cycle after reset is RUN with no pending flush.

Structure
REQ-035 The FSM state enum and the zero-register constant SHALL live in the shared pipeline package, with a load-use helper comparator.
REQ-036 A sub-module is not required; the implementation SHALL be a single module of 120-200 lines.

Verification
REQ-037 Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_rs2_en=1 -> one cycle of pc_stall/ifid_stall/idex_flush=1; stall_cnt 0->1.
REQ-038 Zero destination: same as REQ-037 but ex_rd=0 or id_rs2_en=0 -> no stall and no flush.
REQ-039 Mispredict with FLUSH_EXTRA=2 -> ifid_flush/idex_flush=1 for 3 consecutive cycles, then RUN; a load-use during REDIRECT -> no stall.
REQ-040 Mul/div: md_start=1, md_done asserted 4 cycles later -> 3 stall cycles then release; stall_cnt=3; a mispredict pulse inside MD_WAIT is ignored.
REQ-041 Reset mid-operation: rst=1 during MD_WAIT -> outputs 0 and stall_cnt=0; after release, md_done=1 causes no stall.
REQ-042 Saturation: force stall_cnt near all-ones with CNT_W=4 and hold load-use for 20 cycles -> stall_cnt stays at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// register-file constants and the load-use comparator.
package hazard_ctrl_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MD_WAIT  = 2'd1,
      HZ_REDIRECT = 2'd2
   } hz_state_e;

   // True when the load in EX writes a real register that the instruction in ID reads.
   function automatic logic load_use_hit(
      input logic [REG_W-1:0] rs1,
      input logic             rs1_en,
      input logic [REG_W-1:0] rs2,
      input logic             rs2_en,
      input logic [REG_W-1:0] rd,
      input logic             rd_en,
      input logic             is_load
   );
      logic match;
      match = (rs1_en && (rs1 == rd)) || (rs2_en && (rs2 == rd));
      return is_load && rd_en && (rd != REG_ZERO) && match;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle. The pipeline side (master)
// reports ID/EX operand and event information; the controller side (slave)
// returns stall/flush controls and the stall-cycle counter.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   import hazard_ctrl_pkg::*;

   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_rs1_en;
   logic             id_rs2_en;
   logic [REG_W-1:0] ex_rd;
   logic             ex_rd_en;
   logic             ex_is_load;
   logic             ex_mispredict;
   logic             md_start;
   logic             md_done;

   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_stall;
   logic             idex_flush;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs1, id_rs2, id_rs1_en, id_rs2_en,
      output ex_rd, ex_rd_en, ex_is_load, ex_mispredict,
      output md_start, md_done,
      input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
      input  stall_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_en, id_rs2_en,
      input  ex_rd, ex_rd_en, ex_is_load, ex_mispredict,
      input  md_start, md_done,
      output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
      output stall_cnt
   );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves branch-mispredict redirects, multi-cycle
// mul/div waits and load-use interlocks into PC/IF-ID/ID-EX stall and flush
// controls. Outputs are Mealy: decoded from state, flush counter and inputs.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_EXTRA = 1,
   parameter int CNT_W       = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hif
);

   localparam logic [1:0] ST_RUN      = 2'(HZ_RUN);
   localparam logic [1:0] ST_MD_WAIT  = 2'(HZ_MD_WAIT);
   localparam logic [1:0] ST_REDIRECT = 2'(HZ_REDIRECT);
   localparam logic [1:0] FLUSH_LOAD  = 2'(FLUSH_EXTRA);

   logic [1:0]       state_q, state_d;
   logic [1:0]       flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;

   assign load_use = load_use_hit(hif.id_rs1, hif.id_rs1_en, hif.id_rs2, hif.id_rs2_en,
                                  hif.ex_rd, hif.ex_rd_en, hif.ex_is_load);

   // Next-state and Mealy output decode; reset masks every control output.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_RUN: begin
               // Mispredict beats mul/div issue, which beats the load-use bubble.
               if (hif.ex_mispredict) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  if (FLUSH_LOAD != 2'd0) begin
                     state_d     = ST_REDIRECT;
                     flush_cnt_d = FLUSH_LOAD;
                  end
               end else if (hif.md_start) begin
                  // Issue cycle proceeds; a coincident load-use is re-seen after the wait.
                  state_d = ST_MD_WAIT;
               end else if (load_use) begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_flush = 1'b1;
               end
            end
            ST_MD_WAIT: begin
               if (hif.md_done) begin
                  state_d = ST_RUN;
               end else begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_stall = 1'b1;
               end
            end
            ST_REDIRECT: begin
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               flush_cnt_d = flush_cnt_q - 2'd1;
               if (flush_cnt_q <= 2'd1) begin
                  state_d     = ST_RUN;
                  flush_cnt_d = 2'd0;
               end
            end
            default: begin
               state_d     = ST_RUN;
               flush_cnt_d = 2'd0;
            end
         endcase
      end
   end

   // Stall-cycle counter saturates at all-ones instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State, flush counter and stall counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= 2'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hif.pc_stall   = pc_stall;
   assign hif.ifid_stall = ifid_stall;
   assign hif.ifid_flush = ifid_flush;
   assign hif.idex_stall = idex_stall;
   assign hif.idex_flush = idex_flush;
   assign hif.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (FLUSH_EXTRA=2/CNT_W=32 and
// FLUSH_EXTRA=0/CNT_W=4) share one stimulus stream and are each checked
// against an event-level reference model.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] rs1, rs2, rd;
   logic       e1, e2, rden, ld, mis, mds, mdd;

   hazard_ctrl_if #(.CNT_W(32)) if_a ();
   hazard_ctrl_if #(.CNT_W(4))  if_b ();

   assign if_a.id_rs1 = rs1;   assign if_b.id_rs1 = rs1;
   assign if_a.id_rs2 = rs2;   assign if_b.id_rs2 = rs2;
   assign if_a.id_rs1_en = e1; assign if_b.id_rs1_en = e1;
   assign if_a.id_rs2_en = e2; assign if_b.id_rs2_en = e2;
   assign if_a.ex_rd = rd;     assign if_b.ex_rd = rd;
   assign if_a.ex_rd_en = rden;     assign if_b.ex_rd_en = rden;
   assign if_a.ex_is_load = ld;     assign if_b.ex_is_load = ld;
   assign if_a.ex_mispredict = mis; assign if_b.ex_mispredict = mis;
   assign if_a.md_start = mds;      assign if_b.md_start = mds;
   assign if_a.md_done = mdd;       assign if_b.md_done = mdd;

   hazard_ctrl #(.FLUSH_EXTRA(2), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .hif(if_a));
   hazard_ctrl #(.FLUSH_EXTRA(0), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .hif(if_b));

   // Reference model: remaining flush cycles, mul/div outstanding, stall count.
   int     m_fe  [2] = '{2, 0};
   longint m_max [2] = '{64'hFFFF_FFFF, 15};
   int     m_fl  [2];
   bit     m_busy[2];
   longint m_cnt [2];

   int n_chk  = 0;
   int n_fail = 0;

   function automatic bit lu_ref();
      return ld && rden && (rd != 0) && ((e1 && rs1 == rd) || (e2 && rs2 == rd));
   endfunction

   // Vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush}
   function automatic logic [4:0] exp_out(int k);
      if (rst)           return 5'b00000;
      if (m_fl[k] > 0)   return 5'b00101;
      if (m_busy[k])     return mdd ? 5'b00000 : 5'b11010;
      if (mis)           return 5'b00101;
      if (mds)           return 5'b00000;
      if (lu_ref())      return 5'b11001;
      return 5'b00000;
   endfunction

   function automatic logic [4:0] act_out(int k);
      if (k == 0)
         return {if_a.pc_stall, if_a.ifid_stall, if_a.ifid_flush, if_a.idex_stall, if_a.idex_flush};
      return {if_b.pc_stall, if_b.ifid_stall, if_b.ifid_flush, if_b.idex_stall, if_b.idex_flush};
   endfunction

   function automatic logic [63:0] act_cnt(int k);
      if (k == 0) return 64'(if_a.stall_cnt);
      return 64'(if_b.stall_cnt);
   endfunction

   task automatic clr_in();
      rs1 = 0; rs2 = 0; rd = 0; e1 = 0; e2 = 0; rden = 0; ld = 0;
      mis = 0; mds = 0; mdd = 0;
   endtask

   task automatic rand_in();
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      e1   = $urandom_range(0, 1) == 1;
      e2   = $urandom_range(0, 1) == 1;
      rden = $urandom_range(0, 3) != 0;
      ld   = $urandom_range(0, 1) == 1;
      mis  = $urandom_range(0, 7) == 0;
      mds  = $urandom_range(0, 5) == 0;
      mdd  = $urandom_range(0, 3) == 0;
   endtask

   // Advance one clock and update the model with the inputs seen at that edge.
   task automatic tick();
      logic [4:0] e [2];
      for (int k = 0; k < 2; k++) e[k] = exp_out(k);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_fl[k] = 0; m_busy[k] = 0; m_cnt[k] = 0;
         end else begin
            if (e[k][4] && m_cnt[k] < m_max[k]) m_cnt[k]++;
            if (m_fl[k] > 0)    m_fl[k]--;
            else if (m_busy[k]) begin if (mdd) m_busy[k] = 0; end
            else if (mis)       m_fl[k] = m_fe[k];
            else if (mds)       m_busy[k] = 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clr_in();
      tick();
      tick();
      for (int c = 0; c < 4; c++) begin
         rand_in();
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (act_out(k) !== 5'b00000) begin
               n_fail++;
               $display("FAIL reset_outs dut%0d cyc%0d got %b exp 00000", k, c, act_out(k));
            end
            n_chk++;
            if (act_cnt(k) !== 64'd0) begin
               n_fail++;
               $display("FAIL reset_cnt dut%0d got %0d exp 0", k, act_cnt(k));
            end
         end
         tick();
      end
      rst = 1'b0;
      clr_in();
      #1;
   endtask

   task automatic test_load_use();
      clr_in();
      ld = 1; rden = 1; rd = 5; rs2 = 5; e2 = 1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (act_out(k) !== 5'b11001) begin
            n_fail++;
            $display("FAIL load_use_outs dut%0d got %b exp 11001", k, act_out(k));
         end
      end
      tick();
      clr_in();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (act_out(k) !== 5'b00000) begin
            n_fail++;
            $display("FAIL load_use_release dut%0d got %b exp 00000", k, act_out(k));
         end
         n_chk++;
         if (act_cnt(k) !== 64'd1) begin
            n_fail++;
            $display("FAIL load_use_cnt dut%0d got %0d exp 1", k, act_cnt(k));
         end
      end
   endtask

   task automatic test_zero_dest();
      for (int c = 0; c < 2; c++) begin
         clr_in();
         ld = 1; rden = 1; rs2 = (c == 0) ? 5'd0 : 5'd5; e2 = (c == 0);
         rd = (c == 0) ? 5'd0 : 5'd5;
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (act_out(k) !== 5'b00000 || act_out(k) !== exp_out(k)) begin
               n_fail++;
               $display("FAIL zero_dest dut%0d case%0d got %b exp 00000", k, c, act_out(k));
            end
         end
         tick();
      end
      clr_in();
   endtask

   task automatic test_mispredict();
      int flushes [2];
      flushes = '{0, 0};
      clr_in();
      ld = 1; rden = 1; rd = 7; rs1 = 7; e1 = 1;
      for (int c = 0; c < 6; c++) begin
         mis = (c == 0);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (act_out(k) == 5'b00101) flushes[k]++;
            n_chk++;
            if (act_out(k) !== exp_out(k)) begin
               n_fail++;
               $display("FAIL mispredict dut%0d cyc%0d got %b exp %b", k, c, act_out(k), exp_out(k));
            end
            n_chk++;
            if (act_cnt(k) !== 64'(m_cnt[k])) begin
               n_fail++;
               $display("FAIL mispredict_cnt dut%0d got %0d exp %0d", k, act_cnt(k), m_cnt[k]);
            end
         end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (flushes[k] != m_fe[k] + 1) begin
            n_fail++;
            $display("FAIL flush_len dut%0d got %0d exp %0d", k, flushes[k], m_fe[k] + 1);
         end
      end
      clr_in();
   endtask

   task automatic test_muldiv();
      clr_in();
      rst = 1'b1; tick(); rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         mds = (c == 0); mis = (c == 2); mdd = (c == 4);
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (act_out(k) !== ((c >= 1 && c <= 3) ? 5'b11010 : 5'b00000)) begin
               n_fail++;
               $display("FAIL muldiv dut%0d cyc%0d got %b exp %b", k, c, act_out(k), exp_out(k));
            end
         end
         tick();
      end
      clr_in();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (act_cnt(k) !== 64'd3) begin
            n_fail++;
            $display("FAIL muldiv_cnt dut%0d got %0d exp 3", k, act_cnt(k));
         end
      end
   endtask

   task automatic test_reset_mid();
      clr_in();
      mds = 1; tick();
      mds = 0; tick();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (act_out(k) !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_mid_outs dut%0d got %b exp 00000", k, act_out(k));
         end
      end
      tick();
      rst = 1'b0;
      mdd = 1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (act_out(k) !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_mid_release dut%0d got %b exp 00000", k, act_out(k));
         end
         n_chk++;
         if (act_cnt(k) !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_cnt dut%0d got %0d exp 0", k, act_cnt(k));
         end
      end
      tick();
      clr_in();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rand_in();
         rst = ($urandom_range(0, 63) == 0);
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (act_out(k) !== exp_out(k) || (act_out(k)[1] && act_out(k)[0])) begin
               n_fail++;
               $display("FAIL random dut%0d cyc%0d got %b exp %b", k, c, act_out(k), exp_out(k));
            end
            n_chk++;
            if (act_cnt(k) !== 64'(m_cnt[k])) begin
               n_fail++;
               $display("FAIL random_cnt dut%0d cyc%0d got %0d exp %0d", k, c, act_cnt(k), m_cnt[k]);
            end
         end
         tick();
      end
      rst = 1'b0;
      clr_in();
   endtask

   task automatic test_saturation();
      clr_in();
      rst = 1'b1; tick(); rst = 1'b0;
      ld = 1; rden = 1; rd = 3; rs1 = 3; e1 = 1;
      for (int c = 0; c < 20; c++) begin
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (act_cnt(k) !== 64'(m_cnt[k])) begin
               n_fail++;
               $display("FAIL sat_track dut%0d cyc%0d got %0d exp %0d", k, c, act_cnt(k), m_cnt[k]);
            end
         end
         tick();
      end
      clr_in();
      #1;
      n_chk++;
      if (act_cnt(1) !== 64'd15) begin
         n_fail++;
         $display("FAIL sat_cnt4 got %0d exp 15", act_cnt(1));
      end
      n_chk++;
      if (act_cnt(0) !== 64'd20) begin
         n_fail++;
         $display("FAIL sat_cnt32 got %0d exp 20", act_cnt(0));
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_dest();
      test_mispredict();
      test_muldiv();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
